// File: rtl/hazard_pkg.sv
// ============================================================================
// hazard_pkg : shared defines and types for the pipeline hazard controller
// Rev 1.0
// ============================================================================
`default_nettype none

`ifndef SYS_DEFS_VH
`define SYS_DEFS_VH
`define DONT_BRANCH 3'b000
`define TRUE        1'b1
`endif

package hazard_pkg;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_t;

endpackage

`default_nettype wire

// File: rtl/hz_downcnt.sv
// ============================================================================
// hz_downcnt : loadable down-counter that saturates at zero
// Rev 1.0
// ============================================================================
`default_nettype none

module hz_downcnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] value_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A load wins over a decrement in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : stall/bubble control for the 5-stage in-order pipeline
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int BR_RESOLVE_LAT = 2,
    parameter int MUL_LAT        = 4,
    parameter int REG_ADDR_W     = 5,
    parameter int CNT_W          = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            ID_br_ctrl,
    input  logic [REG_ADDR_W-1:0] ID_rs_addr,
    input  logic [REG_ADDR_W-1:0] ID_rt_addr,
    input  logic                  ID_rs_used,
    input  logic                  ID_rt_used,
    input  logic                  EX_mem_read,
    input  logic [REG_ADDR_W-1:0] EX_dest_addr,
    input  logic                  EX_multi,
    output logic                  ST_if_id_en,
    output logic                  ST_id_ex_en,
    output logic                  ST_ex_mem_en,
    output logic                  ST_mem_wb_en,
    output logic                  ST_id_ex_bubble,
    output logic                  ST_ex_mem_bubble,
    output logic                  ST_br_stall
);

    localparam logic             MC_EN   = (MUL_LAT > 1);
    localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] BR_LOAD = CNT_W'(BR_RESOLVE_LAT - 1);

    mc_state_t        mc_state_q;
    logic [CNT_W-1:0] mc_cnt;
    logic             mc_zero;
    logic [CNT_W-1:0] br_cnt;
    logic             br_zero;

    logic mc_busy;
    logic lu_raw;
    logic lu_hz;
    logic br_id;
    logic br_acc;
    logic id_ex_en;

    // Hazards are masked during reset so outputs fall back to the idle
    // pattern in the same cycle reset is asserted.
    assign mc_busy = !rst && EX_multi && MC_EN &&
                     ((mc_state_q == MC_IDLE) || (mc_cnt > CNT_W'(1)));

    assign lu_raw  = EX_mem_read && (EX_dest_addr != '0) &&
                     ((ID_rs_used && (ID_rs_addr == EX_dest_addr)) ||
                      (ID_rt_used && (ID_rt_addr == EX_dest_addr)));
    assign lu_hz   = !rst && !mc_busy && lu_raw;

    assign br_id   = !rst && (ID_br_ctrl[2:0] != `DONT_BRANCH) && br_zero;
    assign br_acc  = br_id && !mc_busy && !lu_hz;

    assign id_ex_en = !mc_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mc_state_q <= MC_IDLE;
        end else begin
            case (mc_state_q)
                MC_IDLE: if (mc_busy) mc_state_q <= MC_BUSY;
                MC_BUSY: if (mc_cnt <= CNT_W'(1)) mc_state_q <= MC_IDLE;
                default: mc_state_q <= MC_IDLE;
            endcase
        end
    end

    hz_downcnt #(.CNT_W(CNT_W)) u_mc_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     ((mc_state_q == MC_IDLE) && mc_busy),
        .load_val_i (MC_LOAD),
        .dec_i      ((mc_state_q == MC_BUSY) && !mc_zero),
        .value_o    (mc_cnt),
        .zero_o     (mc_zero)
    );

    // The branch window only advances while EX is moving, so a frozen EX
    // stretches the window instead of consuming it.
    hz_downcnt #(.CNT_W(CNT_W)) u_br_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (br_acc),
        .load_val_i (BR_LOAD),
        .dec_i      (id_ex_en && !br_zero),
        .value_o    (br_cnt),
        .zero_o     (br_zero)
    );

    assign ST_if_id_en      = !(mc_busy || lu_hz);
    assign ST_id_ex_en      = id_ex_en;
    assign ST_ex_mem_en     = `TRUE;
    assign ST_mem_wb_en     = `TRUE;
    assign ST_id_ex_bubble  = lu_hz;
    assign ST_ex_mem_bubble = mc_busy;
    assign ST_br_stall      = !rst && (br_id || (br_cnt != '0));

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised pipeline hazard and stall controller for the 5-stage in-order core.
- Replaces the fixed single-cycle branch stall with four mechanisms:
  - a branch-resolution window of configurable length;
  - load-use interlock with bubble insertion into ID/EX;
  - a multi-cycle EX occupancy counter for long-latency ops such as MUL;
  - per-stage register enables plus bubble controls, consumed by the pipeline registers and the fetch unit.

Parameters:
- BR_RESOLVE_LAT, 2: cycles ST_br_stall is held per accepted branch, counting the decode cycle; must be >=1.
- MUL_LAT, 4: total cycles a multi-cycle op occupies EX; must be >=1. A value of 1 means it never stalls.
- REG_ADDR_W, 5: register specifier width.
- CNT_W, 4: counter width; must satisfy 2^CNT_W > max(BR_RESOLVE_LAT, MUL_LAT).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- ID_br_ctrl  in  4  branch control of the instruction in ID; [2:0]==`DONT_BRANCH means not a branch
- ID_rs_addr  in  REG_ADDR_W  ID source register A
- ID_rt_addr  in  REG_ADDR_W  ID source register B
- ID_rs_used  in  1  ID instruction reads rs
- ID_rt_used  in  1  ID instruction reads rt
- EX_mem_read  in  1  instruction in EX is a load
- EX_dest_addr  in  REG_ADDR_W  destination of the instruction in EX
- EX_multi  in  1  instruction in EX is multi-cycle
- ST_if_id_en  out  1  IF/ID register enable
- ST_id_ex_en  out  1  ID/EX register enable
- ST_ex_mem_en  out  1  EX/MEM register enable
- ST_mem_wb_en  out  1  MEM/WB register enable
- ST_id_ex_bubble  out  1  load NOP into ID/EX
- ST_ex_mem_bubble  out  1  load NOP into EX/MEM
- ST_br_stall  out  1  fetch must not advance PC; inject NOP into IF/ID

Behaviour:
- State: mc_state {MC_IDLE, MC_BUSY}, mc_cnt, br_cnt. On rst (async) these reset to MC_IDLE/0/0.
- Outputs are combinational from state and inputs. With reset state and all inputs 0: all enables=1, bubbles=0, ST_br_stall=0.
- Multi-cycle busy: mc_busy = EX_multi && MUL_LAT>1 && (mc_state==MC_IDLE || mc_cnt>1).
  - MC_IDLE && mc_busy → MC_BUSY with mc_cnt=MUL_LAT-1.
  - In MC_BUSY, mc_cnt decrements each cycle. At mc_cnt==1, mc_busy=0 and the next state is MC_IDLE with mc_cnt=0.
  - Net effect: exactly MUL_LAT-1 stall cycles, and the op spends MUL_LAT cycles in EX.
  - A back-to-back multi-cycle op entering EX on the release edge restarts from MC_IDLE.
- While mc_busy: ST_if_id_en=0, ST_id_ex_en=0, ST_ex_mem_en=1, ST_ex_mem_bubble=1, ST_mem_wb_en=1. The downstream stages drain.
- Load-use:
  - lu_hz = EX_mem_read && EX_dest_addr!=0 && ((ID_rs_used && ID_rs_addr==EX_dest_addr) || (ID_rt_used && ID_rt_addr==EX_dest_addr)).
  - Evaluated only when !mc_busy.
  - Response: ST_if_id_en=0, ST_id_ex_en=1, ST_id_ex_bubble=1 for one cycle. The load leaves EX, so the hazard self-clears.
- Branch:
  - br_id = ID_br_ctrl[2:0]!=`DONT_BRANCH && br_cnt==0. The ID branch is ignored while br_cnt!=0.
  - Accepted when br_id && !mc_busy && !lu_hz, i.e. the branch advances into EX. On acceptance, br_cnt loads BR_RESOLVE_LAT-1.
  - br_cnt decrements only in cycles where ST_id_ex_en=1 && br_cnt!=0. It holds while EX is frozen.
  - ST_br_stall = br_id || br_cnt!=0. A branch held in ID by mc_busy or lu_hz keeps ST_br_stall=1 and is not yet counted.
- Priority: mc_busy > lu_hz > branch. Bubbles are never asserted together with the corresponding enable=0.
- rst mid-count: counters are cleared immediately and all outputs return to reset values in the same cycle.

Decomposition:
- Shared header sys_defs.vh keeps `DONT_BRANCH and `TRUE.
- Add a package hazard_pkg with typedef enum logic {MC_IDLE, MC_BUSY} mc_state_t.
- One natural sub-module, hz_downcnt: loadable CNT_W down-counter with load, dec, value and zero outputs, async active-high rst. It is instantiated twice, for mc_cnt and br_cnt.

Test Plan:
- Reset: assert rst mid-MUL (mc_cnt=2) → same cycle, all enables=1, bubbles=0, ST_br_stall=0, and mc_state=MC_IDLE after release.
- MUL_LAT=4: EX_multi=1 held until ST_id_ex_en rises → ST_if_id_en/ST_id_ex_en=0 and ST_ex_mem_bubble=1 for exactly 3 cycles, then released on the 4th.
- Load-use: EX_mem_read=1, EX_dest_addr=5, ID_rt_used=1, ID_rt_addr=5 → one cycle of ST_if_id_en=0 and ST_id_ex_bubble=1. Repeat with EX_dest_addr=0 → no stall.
- BR_RESOLVE_LAT=3: branch in ID, no hazards → ST_br_stall=1 for 3 consecutive cycles, then 0. A second ID_br_ctrl during the window is ignored.
- Branch behind load-use (branch reads load dest) → cycle 1: bubble, ST_br_stall=1, br_cnt stays 0. Then branch accepted, and ST_br_stall stays high for BR_RESOLVE_LAT more cycles.
- Branch accepted, then MUL in EX → br_cnt frozen during 3 busy cycles. ST_br_stall is held for the full busy period plus the remaining count.
